// File: rtl/de_fb_responder.sv
// Drawing-engine memory responder: turns de_req/de_ack word requests into timed
// single-port async SRAM cycles (setup, WAIT_STATES access cycles, ack).
module de_fb_responder #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 1,
  parameter int FB_WORDS    = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic [3:0]        sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic              rnw;
  } req_t;

  localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);

  state_t     state;
  req_t       req;
  logic [3:0] cnt;
  logic       in_range;
  logic       no_op_wr;

  // Widened compare so large addresses never alias into the frame buffer
  assign in_range  = 64'(de_addr) < 64'(FB_WORDS);
  assign no_op_wr  = !de_rnw && (de_nbyte == 4'hF);
  assign sram_addr = req.addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      de_ack     <= 1'b0;
      de_r_data  <= '0;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 4'hF;
      sram_wdata <= '0;
      addr_err   <= 1'b0;
    end else begin
      de_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (de_req) begin
            req <= '{addr: de_addr, nbyte: de_nbyte, rnw: de_rnw};
            if (!in_range || no_op_wr) begin
              // Nothing to do on the SRAM: complete straight away
              state  <= ACK;
              de_ack <= 1'b1;
              if (!in_range) begin
                addr_err <= 1'b1;
                if (de_rnw) de_r_data <= '0;
              end
            end else begin
              state      <= SETUP;
              sram_cs_n  <= 1'b0;
              sram_oe_n  <= !de_rnw;
              sram_wdata <= de_rnw ? 32'h0 : de_w_data;
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= '0;
          if (!req.rnw) sram_we_n <= req.nbyte;
        end
        ACCESS: begin
          if (cnt == LAST) begin
            // Strobes release on the same edge that samples read data
            state      <= ACK;
            de_ack     <= 1'b1;
            sram_cs_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 4'hF;
            sram_wdata <= '0;
            if (req.rnw) de_r_data <= sram_rdata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de_fb_responder.sv
// Bench for de_fb_responder: two instances (1 and 3 wait states) on byte-lane SRAM models,
// directed requests with a scoreboard monitor checking every de_ack.
`timescale 1ns/1ps
module tb_de_fb_responder;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req   [2];
  logic        rnw   [2];
  logic [17:0] addr  [2];
  logic [3:0]  nbyte [2];
  logic [31:0] wdat  [2];
  logic        ack   [2];
  logic [31:0] rdat  [2];
  logic        cs_n  [2];
  logic        oe_n  [2];
  logic [3:0]  we_n  [2];
  logic [17:0] saddr [2];
  logic [31:0] swd   [2];
  logic [31:0] srd   [2];
  logic        aerr  [2];

  int          cs_cnt [2];
  int          oe_cnt [2];
  int          we_cnt [2];
  logic [3:0]  we_last[2];
  exp_t        exp_q  [2][$];

  int checks = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [31:0] mem [256];

    de_fb_responder #(.ADDR_W(18), .WAIT_STATES(g == 0 ? 1 : 3), .FB_WORDS(76800)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .de_req    (req[g]),
      .de_ack    (ack[g]),
      .de_addr   (addr[g]),
      .de_nbyte  (nbyte[g]),
      .de_rnw    (rnw[g]),
      .de_w_data (wdat[g]),
      .de_r_data (rdat[g]),
      .sram_cs_n (cs_n[g]),
      .sram_oe_n (oe_n[g]),
      .sram_we_n (we_n[g]),
      .sram_addr (saddr[g]),
      .sram_wdata(swd[g]),
      .sram_rdata(srd[g]),
      .addr_err  (aerr[g])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = {16'h5AA5, 8'h00, 8'(i)};

    assign srd[g] = (!cs_n[g] && !oe_n[g]) ? mem[saddr[g][7:0]] : 32'h0BAD0BAD;

    always @(posedge clk)
      if (!cs_n[g])
        for (int b = 0; b < 4; b++)
          if (!we_n[g][b]) mem[saddr[g][7:0]][8*b +: 8] = swd[g][8*b +: 8];

    initial begin
      cs_cnt[g] = 0; oe_cnt[g] = 0; we_cnt[g] = 0; we_last[g] = 4'hF;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!cs_n[g]) cs_cnt[g]++;
      if (!oe_n[g]) oe_cnt[g]++;
      if (we_n[g] != 4'hF) begin we_cnt[g]++; we_last[g] = we_n[g]; end
      if (ack[g] === 1'b1) begin
        checks++;
        if (exp_q[g].size() == 0) begin
          fails++;
          $display("FAIL ack_unexpected inst%0d: ack with no request outstanding", g);
        end else begin
          e = exp_q[g].pop_front();
          if ((e.rd && rdat[g] !== e.data) || aerr[g] !== e.err) begin
            fails++;
            $display("FAIL ack_resp inst%0d: r_data=%h addr_err=%b, expected r_data=%h (checked=%0d) addr_err=%b",
                     g, rdat[g], aerr[g], e.data, e.rd, e.err);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns at a negedge once acked (plus an idle cycle unless held)
  task automatic xfer(input int g, input bit r, input logic [17:0] a, input logic [3:0] nb,
                      input logic [31:0] d, input logic [31:0] exp_d, input bit exp_err,
                      input int exp_lat, input bit hold, input bit drop, input string nm);
    int n;
    bit seen;
    req[g] = 1'b1; rnw[g] = r; addr[g] = a; nbyte[g] = nb; wdat[g] = d;
    exp_q[g].push_back('{rd: r, data: exp_d, err: exp_err});
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        req[g] = 1'b0; addr[g] = 18'h3FFFF; rnw[g] = ~r; wdat[g] = 32'hFFFF_FFFF;
      end
      if (ack[g] === 1'b1) seen = 1;
    end
    check({nm, "_latency"}, 64'(n), 64'(exp_lat));
    if (!hold) begin
      req[g] = 1'b0;
      @(negedge clk);
    end
  endtask

  int snap;

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; rnw[g] = 1'b0; addr[g] = '0; nbyte[g] = 4'hF; wdat[g] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ack",   64'(ack[0]),   64'(0));
    check("rst_rdata", 64'(rdat[0]),  64'(0));
    check("rst_cs_n",  64'(cs_n[0]),  64'(1));
    check("rst_oe_n",  64'(oe_n[0]),  64'(1));
    check("rst_we_n",  64'(we_n[0]),  64'(4'hF));
    check("rst_saddr", 64'(saddr[0]), 64'(0));
    check("rst_wdata", 64'(swd[0]),   64'(0));
    check("rst_aerr",  64'(aerr[0]),  64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Byte-0 write then read-back
    snap = we_cnt[0];
    xfer(0, 0, 18'h10, 4'b1110, 32'hAABBCCDD, 32'h0, 0, 3, 0, 0, "wr_byte0");
    check("wr_byte0_we_cycles", 64'(we_cnt[0] - snap), 64'(1));
    check("wr_byte0_we_lanes",  64'(we_last[0]), 64'(4'b1110));
    xfer(0, 1, 18'h10, 4'b0000, 32'h0, 32'h5AA500DD, 0, 3, 0, 0, "rd_byte0");

    // Back-to-back lane writes with de_req held
    xfer(0, 0, 18'h20, 4'b1110, 32'hFFFFFF11, 32'h0, 0, 3, 1, 0, "b2b_w0");
    xfer(0, 0, 18'h20, 4'b1101, 32'hFFFF22FF, 32'h0, 0, 4, 1, 0, "b2b_w1");
    xfer(0, 0, 18'h20, 4'b1011, 32'hFF33FFFF, 32'h0, 0, 4, 1, 0, "b2b_w2");
    xfer(0, 0, 18'h20, 4'b0111, 32'h44FFFFFF, 32'h0, 0, 4, 0, 0, "b2b_w3");
    xfer(0, 1, 18'h20, 4'b1111, 32'h0, 32'h44332211, 0, 3, 0, 0, "b2b_rd");

    // Out-of-range read at exactly FB_WORDS
    snap = cs_cnt[0];
    xfer(0, 1, 18'd76800, 4'b0000, 32'h0, 32'h0, 1, 1, 0, 0, "oor_rd");
    check("oor_rd_no_cs", 64'(cs_cnt[0] - snap), 64'(0));
    check("oor_sticky",   64'(aerr[0]), 64'(1));

    // Write with no lanes enabled is a no-op
    snap = cs_cnt[0];
    xfer(0, 0, 18'h30, 4'hF, 32'h12345678, 32'h0, 1, 1, 0, 0, "nop_wr");
    check("nop_wr_no_cs", 64'(cs_cnt[0] - snap), 64'(0));
    xfer(0, 1, 18'h30, 4'h0, 32'h0, 32'h5AA50030, 1, 3, 0, 0, "nop_rd");

    // de_req dropped and inputs scrambled mid-service
    xfer(0, 1, 18'h10, 4'h0, 32'h0, 32'h5AA500DD, 1, 3, 0, 1, "drop_rd");

    // Three wait states
    snap = oe_cnt[1];
    xfer(1, 1, 18'h40, 4'h0, 32'h0, 32'h5AA50040, 0, 5, 0, 0, "ws3_rd");
    check("ws3_oe_cycles", 64'(oe_cnt[1] - snap), 64'(4));
    snap = we_cnt[1];
    xfer(1, 0, 18'h41, 4'h0, 32'hCAFEF00D, 32'h0, 0, 5, 0, 0, "ws3_wr");
    check("ws3_we_cycles", 64'(we_cnt[1] - snap), 64'(3));
    xfer(1, 1, 18'h41, 4'h0, 32'h0, 32'hCAFEF00D, 0, 5, 0, 0, "ws3_rdback");

    // Reset during the access cycle of a write
    req[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 18'h50; nbyte[0] = 4'h0; wdat[0] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    check("rstacc_we_low", 64'(we_n[0]), 64'(4'h0));
    rst_n = 1'b0;
    #1;
    check("rstacc_we_n", 64'(we_n[0]), 64'(4'hF));
    check("rstacc_cs_n", 64'(cs_n[0]), 64'(1));
    check("rstacc_ack",  64'(ack[0]),  64'(0));
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstacc_aerr_clr", 64'(aerr[0]), 64'(0));
    @(negedge clk);
    xfer(0, 1, 18'h50, 4'h0, 32'h0, 32'h5AA50050, 0, 3, 0, 0, "rstacc_rd");

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("sb_empty%0d", g), 64'(exp_q[g].size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
